ads_spi_master: RTL and testbench
=================================

Name: ads_spi_master

Overview:
- Parametrised SPI master for ADC/DAC register and data access; successor to the fixed 24-bit, mode-1, clk-gated SPI engine.
- Adds generic frame width, selectable CPOL/CPHA, runtime clock divider, owned chip-select with lead/trail/gap timing, and a busy/done handshake.
- Sits between the system-clock control FSM and the converter pins. SCLK is a registered output, never a gated clock.

Parameters:
- DATA_W, 24, bits per frame (8..32), MSB first.
- DIV_W, 8, width of the clk_div input.
- CPOL, 0, SCLK idle level.
- CPHA, 1, 0 = sample on leading edge; 1 = drive on leading edge, sample on trailing edge.
- CS_GAP, 2, minimum clk cycles cs_n stays high between frames (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- wrdat  in  DATA_W  transmit word, latched on accept.
- clk_div  in  DIV_W  half-period = clk_div+1 clk cycles, latched on accept.
- busy  out  1  high from the cycle after accept through the end of GAP.
- done  out  1  one-cycle pulse when a frame completes.
- rddat  out  DATA_W  received word, updated with done.
- cs_n  out  1  chip select, active low.
- sclk  out  1  serial clock, registered.
- mosi  out  1  serial data out, registered.
- miso  in  1  serial data in, sampled in the clk domain.

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-frame): state=IDLE, cs_n=1, sclk=CPOL, mosi=0, busy=0, done=0, rddat=0, shift and bit counters cleared. No done pulse for an aborted frame.
- H = latched clk_div+1. A divider tick occurs every H cycles while in LEAD/XFER/TRAIL.
- FSM states: IDLE -> LEAD -> XFER -> TRAIL -> GAP -> IDLE.
- IDLE: on start=1, latch wrdat and clk_div. Next cycle: cs_n=0, busy=1, state=LEAD. If CPHA=0, mosi=wrdat[DATA_W-1] on that same cycle.
- LEAD: after H cycles, go to XFER.
- XFER: DATA_W bit periods of 2H cycles each. Every tick toggles sclk, alternating leading and trailing edges.
  - CPHA=1: the leading edge drives mosi with the next bit; the trailing edge samples miso.
  - CPHA=0: the leading edge samples miso; the trailing edge shifts in the next mosi bit. No shift after the last bit.
  - After the 2*DATA_W-th edge, sclk=CPOL and state=TRAIL.
- TRAIL: after H cycles, cs_n=1, mosi=0, rddat=received word, done=1 for exactly one cycle, state=GAP.
- GAP: CS_GAP cycles with cs_n=1. Then busy=0 and state=IDLE.
- Frame latency: if accept is at cycle T0, cs_n falls at T0+1 and cs_n rises (with done) at T0+1+(2*DATA_W+2)*H.
- Sampling: miso is sampled on the clk edge at which the sample edge is issued.
- start while busy=1 is ignored; it is not queued. If start is held high, the next frame is accepted on the first IDLE cycle. Back-to-back period is therefore (2*DATA_W+2)*H+CS_GAP+1 cycles.
- Changes to wrdat or clk_div mid-frame have no effect.
- clk_div=0: sclk = clk/2, the maximum rate.
- Bit counter is sized clog2(DATA_W)+1 and does not wrap within a frame.

Test Plan:
- Defaults, clk_div=0, mosi looped to miso, wrdat=24'hA5C3F0, start pulse at T0 -> 24 sclk rising edges; mosi serial pattern A5C3F0 MSB first; rddat=24'hA5C3F0; done single pulse at T0+51; cs_n low for exactly 50 cycles.
- CPHA=0, CPOL=1, DATA_W=8, model slave returns 8'h3C, wrdat=8'h81 -> sclk idles high; first mosi bit valid when cs_n falls; slave captures 8'h81; rddat=8'h3C.
- clk_div=3, DATA_W=24 -> each sclk phase lasts 4 cycles; done at T0+1+50*4=T0+201; clk_div changed to 0 mid-frame has no effect.
- start held high for 3 frames -> cs_n high for exactly CS_GAP+1=3 cycles between frames; three done pulses; busy low for one cycle between frames.
- start pulsed at XFER bit 10 -> ignored: no extra frame, wrdat change not transmitted.
- rst_n low for 1 cycle at bit 12 -> next cycle cs_n=1, sclk=CPOL, mosi=0, busy=0, rddat=0, no done; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/ads_spi_master.sv
// ads_spi_master: SPI master for ADC/DAC register and data access.
//
// A frame is DATA_W bits, MSB first, with selectable CPOL/CPHA. SCLK, MOSI and
// CS_N are plain flops clocked by clk; no clock is ever gated. The SCLK
// half-period is H = clk_div+1 clk cycles, latched when the frame is accepted.
//
// Frame timeline: IDLE -> LEAD (H) -> XFER (2*DATA_W half-periods) -> TRAIL (H)
// -> GAP (CS_GAP cycles) -> IDLE.
//
// Handshake: start acts as a valid and ~busy as the matching ready. A frame is
// accepted at a clk edge where start=1 and busy=0. Requests while busy=1 are
// dropped, not queued. done pulses for one cycle per completed frame, with
// rddat updated in the same cycle. A frame aborted by reset produces no done.
//
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   start        frame request (accepted only in IDLE)
//   wrdat        transmit word, latched on accept
//   clk_div      SCLK half-period minus one, latched on accept
//   busy         high from the cycle after accept through the end of GAP
//   done         one-cycle frame-complete pulse
//   rddat        received word
//   cs_n, sclk,  converter pins, all registered
//   mosi
//   miso         serial input, sampled in the clk domain
//   state_dbg    FSM state: 0=IDLE 1=LEAD 2=XFER 3=TRAIL 4=GAP

module ads_spi_master #(
  parameter int DATA_W = 24,
  parameter int DIV_W  = 8,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b1,
  parameter int CS_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] wrdat,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rddat,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [2:0]        state_dbg
);

  localparam int BCW = $clog2(DATA_W) + 1;
  localparam int GW  = $clog2(CS_GAP + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_XFER  = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [BCW-1:0]    bit_cnt;
  logic              trail_ph;  // 1: the next SCLK edge is a trailing edge
  logic [GW-1:0]     gap_cnt;
  logic              tick;

  // Divider tick: last cycle of the current half-period.
  assign tick      = (div_cnt == div_q);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cs_n     <= 1'b1;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rddat    <= '0;
      div_q    <= '0;
      div_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      bit_cnt  <= '0;
      trail_ph <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_q    <= clk_div;
            div_cnt  <= '0;
            tx_sh    <= wrdat;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            trail_ph <= 1'b0;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            state    <= S_LEAD;
            // CPHA=0 slaves sample on the first edge, so bit 0 must already
            // be on the wire when cs_n falls.
            if (!CPHA) mosi <= wrdat[DATA_W-1];
          end
        end

        S_LEAD: begin
          if (tick) begin
            div_cnt <= '0;
            state   <= S_XFER;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_XFER: begin
          if (tick) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            trail_ph <= ~trail_ph;
            if (!trail_ph) begin
              // Leading edge
              if (CPHA) begin
                mosi  <= tx_sh[DATA_W-1];
                tx_sh <= tx_sh << 1;
              end else begin
                rx_sh <= {rx_sh[DATA_W-2:0], miso};
              end
            end else begin
              // Trailing edge closes one bit period
              if (CPHA) begin
                rx_sh <= {rx_sh[DATA_W-2:0], miso};
              end else if (bit_cnt != LAST_BIT) begin
                mosi  <= tx_sh[DATA_W-2];
                tx_sh <= tx_sh << 1;
              end
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                sclk  <= CPOL;
                state <= S_TRAIL;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_TRAIL: begin
          if (tick) begin
            div_cnt <= '0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            rddat   <= rx_sh;
            done    <= 1'b1;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads_spi_master.sv
// Testbench for ads_spi_master.
// Instance A: defaults (24 bit, CPOL=0, CPHA=1) with mosi looped back to miso.
// Instance B: 8 bit, CPOL=1, CPHA=0 against a small slave model returning 8'h3C.

module tb_ads_spi_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic        a_start = 1'b0;
  logic [23:0] a_wrdat = '0;
  logic [7:0]  a_clk_div = '0;
  logic        a_busy, a_done, a_cs_n, a_sclk, a_mosi;
  logic [23:0] a_rddat;
  logic [2:0]  a_state;
  logic        a_miso;
  assign a_miso = a_mosi;

  ads_spi_master u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .wrdat(a_wrdat),
    .clk_div(a_clk_div), .busy(a_busy), .done(a_done), .rddat(a_rddat),
    .cs_n(a_cs_n), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso),
    .state_dbg(a_state)
  );

  // ---------------- instance B ----------------
  logic       b_start = 1'b0;
  logic [7:0] b_wrdat = '0;
  logic [7:0] b_clk_div = '0;
  logic       b_busy, b_done, b_cs_n, b_sclk, b_mosi;
  logic [7:0] b_rddat;
  logic [2:0] b_state;
  logic       b_miso = 1'b0;

  ads_spi_master #(.DATA_W(8), .DIV_W(8), .CPOL(1'b1), .CPHA(1'b0), .CS_GAP(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .wrdat(b_wrdat),
    .clk_div(b_clk_div), .busy(b_busy), .done(b_done), .rddat(b_rddat),
    .cs_n(b_cs_n), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso),
    .state_dbg(b_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [23:0] tx;
    int          done_cyc;
    int          cs_low;
    int          h;
  } meta_t;

  typedef struct {
    logic [23:0] wrdat;
    logic [7:0]  clk_div;
    logic [23:0] exp_rddat;
    int          exp_done_off;
    int          exp_cs_low;
    int          exp_h;
  } vec_t;

  logic [23:0] exp_q[$];
  meta_t       meta_q[$];
  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor A state ----------------
  int          done_cnt_a = 0;
  int          cs_low_cnt = 0, cs_hi_cnt = 0, busy_lo_cnt = 0;
  int          rise_cnt = 0, tog_cnt = 0, last_tog = 0, ph_min = 0, ph_max = 0;
  int          gap_checks = 0;
  logic [23:0] mosi_cap = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  bit          b2b_chk = 1'b0;

  task automatic monitor_a();
    logic [23:0] e;
    meta_t       m;
    int          iv;
    forever begin
      @(negedge clk);
      if (!a_cs_n) begin
        if (prev_cs) begin
          if (b2b_chk) begin
            check("b2b_cs_high_gap", cs_hi_cnt, 3);
            gap_checks++;
          end
          cs_low_cnt = 1; rise_cnt = 0; mosi_cap = '0;
          tog_cnt = 0; ph_min = 1 << 30; ph_max = 0;
        end else begin
          cs_low_cnt++;
        end
      end else begin
        if (!prev_cs) cs_hi_cnt = 1;
        else cs_hi_cnt++;
      end
      if (!a_cs_n && a_sclk !== prev_sclk) begin
        if (a_sclk) rise_cnt++;
        else mosi_cap = {mosi_cap[22:0], a_mosi};
        if (tog_cnt > 0) begin
          iv = cyc - last_tog;
          if (iv < ph_min) ph_min = iv;
          if (iv > ph_max) ph_max = iv;
        end
        tog_cnt++;
        last_tog = cyc;
      end
      if (!a_busy) begin
        if (prev_busy) busy_lo_cnt = 1;
        else busy_lo_cnt++;
      end else if (!prev_busy && b2b_chk) begin
        check("b2b_busy_low_gap", busy_lo_cnt, 1);
      end
      if (a_done) begin
        done_cnt_a++;
        check("done_single_pulse", prev_done, 0);
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          m = meta_q.pop_front();
          check("rddat", a_rddat, e);
          check("done_cycle", cyc, m.done_cyc);
          check("cs_low_cycles", cs_low_cnt, m.cs_low);
          check("sclk_rises", rise_cnt, 24);
          check("mosi_pattern", mosi_cap, m.tx);
          check("sclk_phase_min", ph_min, m.h);
          check("sclk_phase_max", ph_max, m.h);
        end
      end
      prev_cs = a_cs_n; prev_sclk = a_sclk; prev_busy = a_busy; prev_done = a_done;
    end
  endtask

  // ---------------- monitor B / slave model ----------------
  int         b_done_cnt = 0, b_done_cyc = 0;
  logic [7:0] sl_tx = '0, sl_rx = '0;
  logic       b_prev_cs = 1'b1, b_prev_sclk = 1'b1;

  task automatic monitor_b();
    forever begin
      @(negedge clk);
      if (!b_cs_n && b_prev_cs) begin
        sl_tx = 8'h3C; sl_rx = '0; b_miso = sl_tx[7];
      end else if (!b_cs_n && b_sclk !== b_prev_sclk) begin
        if (!b_sclk) begin
          sl_rx = {sl_rx[6:0], b_mosi};        // leading (falling) edge
        end else begin
          sl_tx = {sl_tx[6:0], 1'b0};          // trailing (rising) edge
          b_miso = sl_tx[7];
        end
      end
      if (b_done) begin
        b_done_cnt++;
        b_done_cyc = cyc;
      end
      b_prev_cs = b_cs_n; b_prev_sclk = b_sclk;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_frame_a(input vec_t v, output int t0);
    meta_t m;
    @(posedge clk); #1;
    a_wrdat = v.wrdat; a_clk_div = v.clk_div; a_start = 1'b1;
    t0 = cyc;
    m.tx = v.wrdat; m.done_cyc = t0 + v.exp_done_off; m.cs_low = v.exp_cs_low; m.h = v.exp_h;
    exp_q.push_back(v.exp_rddat);
    meta_q.push_back(m);
    @(posedge clk); #1;
    a_start = 1'b0;
    check("busy_after_accept", a_busy, 1);
    check("cs_low_after_accept", a_cs_n, 0);
    // Inputs are latched on accept; scramble them for the rest of the frame.
    a_wrdat = 24'($urandom());
    a_clk_div = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done_a(input int target, input int budget);
    int k = 0;
    while (done_cnt_a < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("frame_done_in_budget", done_cnt_a >= target, 1);
  endtask

  task automatic run_frame_b(input logic [7:0] w, input logic [7:0] d, input int done_off);
    int t0;
    int base;
    int k = 0;
    base = b_done_cnt;
    @(posedge clk); #1;
    b_wrdat = w; b_clk_div = d; b_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    b_start = 1'b0;
    check("b_cs_low_after_accept", b_cs_n, 0);
    check("b_first_mosi_bit", b_mosi, w[7]);
    check("b_sclk_idle_high", b_sclk, 1);
    b_wrdat = ~w; b_clk_div = 8'd0;
    while (b_done_cnt == base && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("b_done_in_budget", b_done_cnt, base + 1);
    check("b_done_cycle", b_done_cyc, t0 + done_off);
    check("b_rddat", b_rddat, 8'h3C);
    check("b_slave_captured", sl_rx, w);
    @(posedge clk); #1;
    check("b_sclk_idle_after", b_sclk, 1);
  endtask

  // ---------------- main test ----------------
  vec_t vecs[5];
  vec_t v;

  initial begin
    int t0;
    int base;
    vecs[0] = '{24'hA5C3F0, 8'd0, 24'hA5C3F0,  51,  50, 1};
    vecs[1] = '{24'h000001, 8'd1, 24'h000001, 101, 100, 2};
    vecs[2] = '{24'hFFFFFF, 8'd0, 24'hFFFFFF,  51,  50, 1};
    vecs[3] = '{24'h5A0F96, 8'd3, 24'h5A0F96, 201, 200, 4};
    vecs[4] = '{24'h800000, 8'd2, 24'h800000, 151, 150, 3};

    fork
      monitor_a();
      monitor_b();
    join_none

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", a_cs_n, 1);
    check("rst_sclk", a_sclk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rddat", a_rddat, 0);
    check("rst_state", a_state, 0);
    check("b_rst_cs_n", b_cs_n, 1);
    check("b_rst_sclk", b_sclk, 1);
    check("b_rst_mosi", b_mosi, 0);
    check("b_rst_busy", b_busy, 0);
    check("b_rst_rddat", b_rddat, 0);
    check("b_rst_state", b_state, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven frames on A
    for (int i = 0; i < 5; i++) begin
      base = done_cnt_a;
      run_frame_a(vecs[i], t0);
      wait_done_a(base + 1, 300);
      repeat (5) @(posedge clk);
      #1;
      check("idle_after_frame", a_state, 0);
    end

    // CPHA=0 / CPOL=1 frames on B
    run_frame_b(8'h81, 8'd1, 37);
    repeat (4) @(posedge clk);
    run_frame_b(8'h5A, 8'd0, 19);
    repeat (4) @(posedge clk);

    // start held high for three back-to-back frames
    begin
      meta_t m;
      base = done_cnt_a;
      gap_checks = 0;
      @(posedge clk); #1;
      a_wrdat = 24'h3C96E1; a_clk_div = 8'd0; a_start = 1'b1;
      t0 = cyc;
      for (int f = 0; f < 3; f++) begin
        m.tx = 24'h3C96E1; m.cs_low = 50; m.h = 1;
        m.done_cyc = t0 + 51 + 53 * f;
        exp_q.push_back(24'h3C96E1);
        meta_q.push_back(m);
      end
      repeat (3) @(posedge clk);
      #1 b2b_chk = 1'b1;
      repeat (104) @(posedge clk);
      #1 a_start = 1'b0;
      wait_done_a(base + 3, 200);
      b2b_chk = 1'b0;
      check("b2b_gap_count", gap_checks, 2);
      repeat (5) @(posedge clk);
    end

    // start pulsed during XFER bit 10 is ignored
    base = done_cnt_a;
    v = '{24'h3C3C3C, 8'd0, 24'h3C3C3C, 51, 50, 1};
    run_frame_a(v, t0);
    while (cyc < t0 + 22) begin
      @(posedge clk); #1;
    end
    a_wrdat = 24'hFFFF00; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    wait_done_a(base + 1, 200);
    repeat (120) @(posedge clk);
    #1;
    check("ignored_start_no_extra", done_cnt_a - base, 1);
    check("ignored_start_cs_idle", a_cs_n, 1);
    check("ignored_start_busy", a_busy, 0);

    // Reset pulse at bit 12 aborts the frame
    v = '{24'hC0FFEE, 8'd0, 24'hC0FFEE, 51, 50, 1};
    run_frame_a(v, t0);
    while (cyc < t0 + 26) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    meta_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_cs_n", a_cs_n, 1);
    check("abort_sclk", a_sclk, 0);
    check("abort_mosi", a_mosi, 0);
    check("abort_busy", a_busy, 0);
    check("abort_rddat", a_rddat, 0);
    check("abort_done", a_done, 0);
    check("abort_state", a_state, 0);
    base = done_cnt_a;
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt_a - base, 0);

    // Fresh frame after the abort
    v = '{24'h123456, 8'd1, 24'h123456, 101, 100, 2};
    run_frame_a(v, t0);
    wait_done_a(base + 1, 300);
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
